// File: rtl/lfsr_gen.sv
// Galois LFSR generator with seed load, all-zero lockup protection
// and measurement of the period of the last completed cycle.
module lfsr_gen #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'b00101),
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    logic [WIDTH-1:0] ref_state;
    logic [WIDTH-1:0] step_cnt;

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] cnt_inc;
    logic             hit_ref;
    logic             seed_zero;

    // One Galois step, and whether it lands back on the reference state
    always_comb begin
        step_val  = {q[WIDTH-2:0], 1'b0};
        if (q[WIDTH-1]) begin
            step_val = step_val ^ TAPS;
        end
        cnt_inc   = step_cnt + 1'b1;
        hit_ref   = (step_val == ref_state);
        seed_zero = (seed_in == '0);
    end

    // State update: reset > load > step > hold; pulses default low
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q         <= SEED;
            ref_state <= SEED;
            step_cnt  <= '0;
            period    <= '0;
            wrap      <= 1'b0;
            lockup    <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                step_cnt <= '0;
                if (seed_zero) begin
                    // an all-zero state would stick forever
                    q         <= SEED;
                    ref_state <= SEED;
                    lockup    <= 1'b1;
                end else begin
                    q         <= seed_in;
                    ref_state <= seed_in;
                end
            end else if (en) begin
                q <= step_val;
                if (hit_ref) begin
                    step_cnt <= '0;
                    period   <= cnt_inc;
                    wrap     <= 1'b1;
                end else begin
                    step_cnt <= cnt_inc;
                end
            end
        end
    end

    assign bit_out = q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomized and directed bench for lfsr_gen (default parameters)
// against a behavioural model of the sequence and period rules.
module tb_lfsr_gen;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         en;
    logic         load;
    logic [W-1:0] seed_in;
    logic [W-1:0] q;
    logic         bit_out;
    logic         wrap;
    logic [W-1:0] period;
    logic         lockup;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int m_q, m_ref, m_cnt, m_per;
    bit m_wrap, m_lock;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .en      (en),
        .load    (load),
        .seed_in (seed_in),
        .q       (q),
        .bit_out (bit_out),
        .wrap    (wrap),
        .period  (period),
        .lockup  (lockup)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // x^5 + x^2 + 1 in Galois form, as plain arithmetic on integers
    function automatic int step_of(input int x);
        int v;
        v = (x * 2) % 32;
        if (x >= 16) v = v ^ 5;
        return v;
    endfunction

    task automatic model(input bit r, input bit l, input bit e,
                         input int s);
        int nx;
        m_wrap = 0;
        m_lock = 0;
        if (!r) begin
            m_q = 31; m_ref = 31; m_cnt = 0; m_per = 0;
        end else if (l) begin
            m_cnt = 0;
            if (s == 0) begin
                m_q = 31; m_ref = 31; m_lock = 1;
            end else begin
                m_q = s; m_ref = s;
            end
        end else if (e) begin
            nx = step_of(m_q);
            if (nx == m_ref) begin
                m_per  = (m_cnt + 1) % 32;
                m_cnt  = 0;
                m_wrap = 1;
            end else begin
                m_cnt = (m_cnt + 1) % 32;
            end
            m_q = nx;
        end
    endtask

    task automatic cycle(input bit r, input bit l, input bit e,
                         input int s);
        @(negedge clk);
        rst_b   = r;
        load    = l;
        en      = e;
        seed_in = W'(s);
        @(posedge clk);
        model(r, l, e, s);
        #1;
        chk("q", q, m_q);
        chk("bit_out", bit_out, (m_q >= 16) ? 1 : 0);
        chk("wrap", wrap, m_wrap);
        chk("period", period, m_per);
        chk("lockup", lockup, m_lock);
    endtask

    initial begin
        int e29 [4];
        bit [31:0] seen;
        int wraps;
        int n;
        int mq_prev;
        bit e;

        rst_b = 1'b0; load = 1'b0; en = 1'b0; seed_in = '0;
        e29 = '{27, 19, 3, 6};

        // reset wins over load and en
        cycle(0, 1, 1, 0);
        chk("rst_q", q, 31);
        chk("rst_period", period, 0);

        // first four steps from the default seed
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 1, 0);
            chk("seq4", q, e29[i]);
        end

        // continuous run: two full periods, every nonzero state once
        cycle(0, 0, 0, 0);
        seen  = '0;
        wraps = 0;
        for (int i = 1; i <= 62; i++) begin
            cycle(1, 0, 1, 0);
            if (i <= 31) seen[q] = 1'b1;
            if (wrap) begin
                wraps++;
                chk("wrap_step", i % 31, 0);
                chk("wrap_q", q, 31);
                chk("wrap_per", period, 31);
            end
        end
        chk("wraps_62", wraps, 2);
        chk("distinct", $countones(seen), 31);
        chk("zero_seen", seen[0], 0);

        // load beats en; period measured from the loaded value
        cycle(1, 1, 1, 3);
        chk("load_q", q, 3);
        chk("load_wrap", wrap, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 1, 0);
            n++;
            if (wrap) break;
        end
        chk("load_steps", n, 31);
        chk("load_wrap_q", q, 3);
        chk("load_per", period, 31);

        // all-zero load substitutes the seed and flags lockup once
        cycle(1, 1, 0, 0);
        chk("zl_q", q, 31);
        chk("zl_lock", lockup, 1);
        chk("zl_wrap", wrap, 0);
        cycle(1, 0, 0, 0);
        chk("zl_lock_off", lockup, 0);

        // reset mid-sequence discards the count
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("mid_rst_q", q, 31);
        chk("mid_rst_per", period, 0);
        chk("mid_rst_wrap", wrap, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 1, 0);
            n++;
            if (wrap) break;
        end
        chk("mid_rst_steps", n, 31);
        chk("mid_rst_per31", period, 31);

        // alternating enable: hold on low cycles, one wrap in 62
        cycle(0, 0, 0, 0);
        wraps = 0;
        for (int i = 0; i < 62; i++) begin
            e = (i % 2 == 0);
            mq_prev = m_q;
            cycle(1, 0, e, 0);
            if (!e) chk("alt_hold", q, mq_prev);
            if (wrap) wraps++;
        end
        chk("alt_wraps", wraps, 1);
        chk("alt_per", period, 31);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, l, en_r;
            int s;
            r    = ($urandom_range(0, 199) != 0);
            l    = ($urandom_range(0, 39) == 0);
            en_r = ($urandom_range(0, 9) < 7);
            s    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
            cycle(r, l, en_r, s);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 5: register width; legal range 3..32.
REQ-002 Parameter TAPS, default 5'b00101 (WIDTH bits): Galois feedback mask; bit i set means q[WIDTH-1] is XORed into next[i].
REQ-003 Parameter SEED, default all ones (WIDTH bits): reset and recovery state; SHALL be nonzero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_b  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  advance the register one step this cycle.
REQ-007 load  input  1  load seed_in this cycle.
REQ-008 seed_in  input  WIDTH  value to load.
REQ-009 q  output  WIDTH  current LFSR state, registered.
REQ-010 bit_out  output  1  serial output, equals q[WIDTH-1].
REQ-011 wrap  output  1  one-cycle pulse: state returned to reference value.
REQ-012 period  output  WIDTH  step count of the last completed cycle, registered.
REQ-013 lockup  output  1  one-cycle pulse: all-zero load was rejected.

Function
REQ-014 Step rule: next = {q[WIDTH-2:0],1'b0} XOR (q[WIDTH-1] ? TAPS : 0); TAPS[0] SHALL be 1.
REQ-015 Priority per cycle: rst_b low > load > en > hold.
REQ-016 en low and load low: q, ref, step_cnt, period held; wrap and lockup low.
REQ-017 Internal ref register holds the reference state: SEED after reset, loaded value after load.
REQ-018 Load with seed_in nonzero: q <= seed_in, ref <= seed_in, step_cnt <= 0 next edge; period unchanged; no wrap.
REQ-019 Load with seed_in == 0: q <= SEED, ref <= SEED, step_cnt <= 0, lockup = 1 for the following cycle.
REQ-020 Load and en both high: load wins; no step taken that cycle.
REQ-021 Internal step_cnt (WIDTH bits) increments on each step, wrapping modulo 2^WIDTH.
REQ-022 Step whose next equals ref: step_cnt <= 0, period <= step_cnt + 1 (modulo 2^WIDTH), wrap = 1 for the following cycle.
REQ-023 Step whose next differs from ref: step_cnt <= step_cnt + 1; wrap low.
REQ-024 Latency: q, wrap, period and lockup all update on the edge that samples the qualifying input; no further pipeline delay.
REQ-025 q SHALL never hold all zeros in operation; all-zero loads are substituted per REQ-019.
REQ-026 Back-to-back en SHALL advance once per cycle with no bubbles; wrap SHALL repeat every period cycles under continuous en.

Reset
REQ-027 rst_b low at an edge: q = SEED, ref = SEED, step_cnt = 0, period = 0, wrap = 0, lockup = 0, regardless of en and load.
REQ-028 Reset mid-sequence discards the step count; the first wrap after reset reports a full period from SEED.

Verification
REQ-029 Defaults; reset, then en=1 for 4 cycles -> q = 11111, 11011, 10011, 00011, 00110.
REQ-030 Defaults; continuous en from reset -> wrap pulses after step 31 with q = 11111 and period = 31; repeats every 31 cycles; all 31 nonzero states seen exactly once per cycle.
REQ-031 load=1, seed_in=00011, en=1 together -> q = 00011 next cycle, no step; continuous en then gives wrap with period = 31 when q returns to 00011.
REQ-032 load=1, seed_in=00000 -> q = 11111, lockup high exactly one cycle, wrap low.
REQ-033 rst_b low for one edge mid-sequence with en=1 -> q = 11111, period = 0, wrap = 0 next cycle; the following wrap reports period = 31.
REQ-034 en toggled 1/0 alternately for 62 cycles -> q advances only on en-high cycles; wrap once with period = 31; q, period held during en-low cycles.
